bounce_seq_checker: RTL and testbench

Receive-side monitor for the 4-bit bounce counter stream. The counter sequence is 0,1..15,15,14..0,0,1.., with a one-cycle dwell at each endpoint except the very first 0 after counter reset.
The checker samples the stream and runs a reference model of it. It acquires lock, reports direction, dwell and period events, and flags and counts sequence errors.
It sits next to the counter in self-checking tops and on boards, feeding status LEDs and error counters.

---
 rtl/bounce_seq_checker_if.sv | 39 +++
 rtl/bounce_seq_checker.sv | 199 +++++++++++++++++++
 tb/tb_bounce_seq_checker.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/bounce_seq_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : bounce_seq_checker_if
// Purpose  : Bundles the sampled bounce-counter stream and the checker status
//            outputs into one port.
// Signals  : en      - sample enable (master -> slave)
//            s       - observed counter value, WIDTH bits (master -> slave)
//            locked  - checker model synchronised to the stream
//            dir     - model direction, 0=up 1=down
//            dwell   - pulse: endpoint repeat accepted while locked
//            period  - pulse: repeat at 0 accepted while locked
//            err     - pulse: mismatch while locked
//            err_cnt - saturating error count, ERR_W bits
// Revision : 1.0 - initial release
// ============================================================================
interface bounce_seq_checker_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  logic             en;
  logic [WIDTH-1:0] s;
  logic             locked;
  logic             dir;
  logic             dwell;
  logic             period;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output en, s,
    input  locked, dir, dwell, period, err, err_cnt
  );

  modport slave (
    input  en, s,
    output locked, dir, dwell, period, err, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/bounce_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : bounce_seq_checker
// Purpose  : Receive-side monitor for the bounce counter stream
//            0,1..MAX,MAX,MAX-1..0,0,1.. . Runs a reference model of the
//            stream, acquires lock after LOCK_LEN consecutive valid steps,
//            reports direction/dwell/period events and counts mismatches.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - slave modport: en/s in; locked, dir, dwell, period,
//                   err, err_cnt out (all registered, one-cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
module bounce_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 4,
  parameter int ERR_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  bounce_seq_checker_if.slave  bus
);

  localparam int               CNT_W     = 4;
  localparam logic [WIDTH-1:0] c_MAX     = '1;
  localparam logic [WIDTH-1:0] c_ZERO    = '0;
  localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);
  localparam logic [CNT_W-1:0] c_LOCK    = CNT_W'(LOCK_LEN);
  localparam logic [ERR_W-1:0] c_ERR_MAX = '1;

  typedef enum logic [0:0] {
    ST_ACQ    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           r_state,   w_state;
  logic             r_have_prev, w_have_prev;
  logic             r_cls,     w_cls;      // model classified within this ACQ run
  logic [WIDTH-1:0] r_prev,    w_prev;
  logic             r_dir,     w_dir;
  logic             r_held,    w_held;
  logic [CNT_W-1:0] r_cnt,     w_cnt;
  logic             r_dwell,   w_dwell;
  logic             r_period,  w_period;
  logic             r_err,     w_err;
  logic [ERR_W-1:0] r_err_cnt, w_err_cnt;

  logic [WIDTH-1:0] w_inc, w_dec;
  logic [WIDTH-1:0] w_pred;
  logic             w_pred_dir, w_pred_held;

  assign w_inc = r_prev + c_ONE;
  assign w_dec = r_prev - c_ONE;

  // Prediction of the next sample. The direction flips on the endpoint
  // repeat itself, so dir already shows where the stream heads next.
  always_comb begin
    w_pred      = r_prev;
    w_pred_dir  = r_dir;
    w_pred_held = 1'b0;
    if (r_prev == c_MAX && !r_dir && !r_held) begin
      w_pred      = c_MAX;
      w_pred_held = 1'b1;
      w_pred_dir  = 1'b1;
    end else if (r_prev == c_MAX && r_held) begin
      w_pred      = w_dec;
      w_pred_dir  = 1'b1;
    end else if (r_prev == c_ZERO && r_dir && !r_held) begin
      w_pred      = c_ZERO;
      w_pred_held = 1'b1;
      w_pred_dir  = 1'b0;
    end else if (r_prev == c_ZERO && r_held) begin
      w_pred      = c_ONE;
      w_pred_dir  = 1'b0;
    end else if (!r_dir) begin
      w_pred      = w_inc;
    end else begin
      w_pred      = w_dec;
    end
  end

  // Next-state and output logic
  always_comb begin
    w_state     = r_state;
    w_have_prev = r_have_prev;
    w_cls       = r_cls;
    w_prev      = r_prev;
    w_dir       = r_dir;
    w_held      = r_held;
    w_cnt       = r_cnt;
    w_dwell     = 1'b0;
    w_period    = 1'b0;
    w_err       = 1'b0;
    w_err_cnt   = r_err_cnt;

    if (bus.en) begin
      case (r_state)
        ST_ACQ: begin
          w_prev = bus.s;
          if (!r_have_prev) begin
            w_have_prev = 1'b1;
            w_cls       = 1'b0;
            w_cnt       = '0;
          end else if (!r_cls) begin
            // First valid pair of the run seeds the model and counts as a step
            w_cls = 1'b1;
            w_cnt = CNT_W'(1);
            if (bus.s == w_inc && r_prev != c_MAX) begin
              w_dir  = 1'b0;
              w_held = 1'b0;
            end else if (bus.s == w_dec && r_prev != c_ZERO) begin
              w_dir  = 1'b1;
              w_held = 1'b0;
            end else if (bus.s == r_prev && r_prev == c_MAX) begin
              w_dir  = 1'b1;
              w_held = 1'b1;
            end else if (bus.s == r_prev && r_prev == c_ZERO) begin
              w_dir  = 1'b0;
              w_held = 1'b1;
            end else begin
              w_cls = 1'b0;
              w_cnt = '0;
            end
          end else if (bus.s == w_pred) begin
            w_dir  = w_pred_dir;
            w_held = w_pred_held;
            w_cnt  = r_cnt + CNT_W'(1);
          end else begin
            w_cls = 1'b0;
            w_cnt = '0;
          end
          if (w_cnt == c_LOCK) begin
            w_state = ST_LOCKED;
          end
        end

        ST_LOCKED: begin
          w_prev = bus.s;
          if (bus.s == w_pred) begin
            w_dir    = w_pred_dir;
            w_held   = w_pred_held;
            w_dwell  = w_pred_held;
            w_period = w_pred_held && (w_pred == c_ZERO);
          end else begin
            w_err       = 1'b1;
            w_state     = ST_ACQ;
            w_have_prev = 1'b1;
            w_cls       = 1'b0;
            w_cnt       = '0;
            if (r_err_cnt != c_ERR_MAX) begin
              w_err_cnt = r_err_cnt + ERR_W'(1);
            end
          end
        end

        default: begin
          w_state = ST_ACQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_ACQ;
      r_have_prev <= 1'b0;
      r_cls       <= 1'b0;
      r_prev      <= '0;
      r_dir       <= 1'b0;
      r_held      <= 1'b0;
      r_cnt       <= '0;
      r_dwell     <= 1'b0;
      r_period    <= 1'b0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state;
      r_have_prev <= w_have_prev;
      r_cls       <= w_cls;
      r_prev      <= w_prev;
      r_dir       <= w_dir;
      r_held      <= w_held;
      r_cnt       <= w_cnt;
      r_dwell     <= w_dwell;
      r_period    <= w_period;
      r_err       <= w_err;
      r_err_cnt   <= w_err_cnt;
    end
  end

  assign bus.locked  = (r_state == ST_LOCKED);
  assign bus.dir     = r_dir;
  assign bus.dwell   = r_dwell;
  assign bus.period  = r_period;
  assign bus.err     = r_err;
  assign bus.err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bounce_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_bounce_seq_checker
// Purpose  : Directed bench for bounce_seq_checker. Two instances share one
//            stimulus stream: dut_a with ERR_W=8 and dut_b with ERR_W=2 for
//            the saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bounce_seq_checker;
  localparam int WIDTH    = 4;
  localparam int LOCK_LEN = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bounce_seq_checker_if #(.WIDTH(WIDTH), .ERR_W(8)) bus_a ();
  bounce_seq_checker_if #(.WIDTH(WIDTH), .ERR_W(2)) bus_b ();

  bounce_seq_checker #(.WIDTH(WIDTH), .LOCK_LEN(LOCK_LEN), .ERR_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  bounce_seq_checker #(.WIDTH(WIDTH), .LOCK_LEN(LOCK_LEN), .ERR_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct {
    logic       en;
    logic [3:0] s;
    logic       locked;
    logic       dir;
    logic       dwell;
    logic       period;
    logic       err;
    logic [7:0] err_cnt;
  } vec_t;

  vec_t tbl [58];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Bounce stream sample at index idx (period 32, first 0 has no dwell)
  function automatic logic [3:0] bval(int idx);
    int k;
    k = idx % 32;
    return (k < 16) ? 4'(k) : 4'(31 - k);
  endfunction

  function automatic vec_t mk(logic l, logic d, logic dw, logic pe, logic e, logic [7:0] c);
    vec_t v;
    v.en = 1'b1; v.s = 4'd0;
    v.locked = l; v.dir = d; v.dwell = dw; v.period = pe; v.err = e; v.err_cnt = c;
    return v;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_vec(string tag, vec_t v);
    chk({tag, " locked"}, 8'(bus_a.locked), 8'(v.locked));
    if (v.locked) chk({tag, " dir"}, 8'(bus_a.dir), 8'(v.dir));
    chk({tag, " dwell"},   8'(bus_a.dwell),  8'(v.dwell));
    chk({tag, " period"},  8'(bus_a.period), 8'(v.period));
    chk({tag, " err"},     8'(bus_a.err),    8'(v.err));
    chk({tag, " err_cnt"}, bus_a.err_cnt,    v.err_cnt);
    chk({tag, " err_cnt_sat"}, 8'(bus_b.err_cnt), (v.err_cnt > 8'd3) ? 8'd3 : v.err_cnt);
  endtask

  task automatic drive(logic e, logic [3:0] v);
    bus_a.en = e; bus_a.s = v;
    bus_b.en = e; bus_b.s = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t pv, hv, ev;
    int   p;

    bus_a.en = 1'b0; bus_a.s = '0;
    bus_b.en = 1'b0; bus_b.s = '0;

    // Expected outputs for the continuous stream from reset
    for (int i = 0; i < 58; i++) begin
      tbl[i].en      = 1'b1;
      tbl[i].s       = bval(i);
      tbl[i].locked  = (i >= 4);
      tbl[i].dir     = (i >= 4) && ((i % 32) >= 16);
      tbl[i].dwell   = (i >= 16) && ((i % 16) == 0);
      tbl[i].period  = (i >= 32) && ((i % 32) == 0);
      tbl[i].err     = 1'b0;
      tbl[i].err_cnt = 8'd0;
    end

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_vec("reset", mk(0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    // Continuous stream: lock after sample 4, dwell at 16/32/48, period at 32
    for (int i = 0; i < 58; i++) begin
      drive(tbl[i].en, tbl[i].s);
      chk_vec($sformatf("run idx%0d", i), tbl[i]);
    end

    // Glitch on the down slope: 7 instead of 5, then clean 4,3,2,1,0
    drive(1'b1, 4'd7);  chk_vec("glitch7",   mk(0, 0, 0, 0, 1, 1));
    drive(1'b1, 4'd4);  chk_vec("after g 4", mk(0, 0, 0, 0, 0, 1));
    drive(1'b1, 4'd3);  chk_vec("after g 3", mk(0, 0, 0, 0, 0, 1));
    drive(1'b1, 4'd2);  chk_vec("after g 2", mk(0, 0, 0, 0, 0, 1));
    drive(1'b1, 4'd1);  chk_vec("after g 1", mk(0, 0, 0, 0, 0, 1));
    drive(1'b1, 4'd0);  chk_vec("relock 0",  mk(1, 1, 0, 0, 0, 1));
    drive(1'b1, 4'd0);  chk_vec("rep 0",     mk(1, 0, 1, 1, 0, 1));
    drive(1'b1, 4'd1);  chk_vec("up 1",      mk(1, 0, 0, 0, 0, 1));
    drive(1'b1, 4'd2);  chk_vec("up 2",      mk(1, 0, 0, 0, 0, 1));

    // Second glitch to reach err_cnt=2, then relock on the up slope
    drive(1'b1, 4'd9);  chk_vec("glitch9",   mk(0, 0, 0, 0, 1, 2));
    for (int v = 4; v <= 7; v++) begin
      drive(1'b1, 4'(v));
      chk_vec($sformatf("acq %0d", v), mk(0, 0, 0, 0, 0, 2));
    end
    drive(1'b1, 4'd8);  chk_vec("relock 8",  mk(1, 0, 0, 0, 0, 2));

    // Asynchronous reset mid-cycle while locked: outputs clear before any edge
    #2 rst = 1'b1;
    #1;
    chk_vec("async rst", mk(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 rst = 1'b0;

    // en toggling: same results per enabled sample, outputs hold otherwise
    pv = mk(0, 0, 0, 0, 0, 0);
    for (int i = 0; i <= 40; i++) begin
      hv = pv; hv.dwell = 1'b0; hv.period = 1'b0; hv.err = 1'b0;
      drive(1'b0, ~bval(i));
      chk_vec($sformatf("gated hold idx%0d", i), hv);
      drive(1'b1, bval(i));
      chk_vec($sformatf("gated idx%0d", i), tbl[i]);
      pv = tbl[i];
    end

    // Five glitches with relock between each; ERR_W=2 instance saturates at 3
    p = 41;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, bval(p) ^ 4'h8);
      chk_vec($sformatf("sat glitch%0d", k), mk(0, 0, 0, 0, 1, 8'(k + 1)));
      for (int j = 1; j <= 5; j++) begin
        ev = mk((j == 5), ((p + j) % 32) >= 16, 0, 0, 0, 8'(k + 1));
        drive(1'b1, bval(p + j));
        chk_vec($sformatf("sat relock%0d.%0d", k, j), ev);
      end
      p = p + 6;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
